// File: rtl/noc_mon_pkg.sv
// Shared types, default parameter values and the saturating adder used by the
// NoC performance monitor and its outstanding-transaction tracker.
package noc_mon_pkg;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_ID_W          = 8;
    localparam int DEF_MAX_OUT       = 16;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_LAT_THRESH    = 100;

    // Table fields are stored at these maximum widths; narrower ch/id are zero-extended.
    localparam int TXN_CH_W = 8;
    localparam int TXN_ID_W = 32;

    typedef struct packed {
        logic                valid;
        logic [TXN_CH_W-1:0] ch;
        logic [TXN_ID_W-1:0] id;
        logic [31:0]         ts;
    } txn_entry_t;

    typedef enum logic {IDLE, RUN} mon_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/noc_txn_tracker.sv
// Outstanding-transaction table: lowest-free allocation on request, lowest-index
// {ch,id} match on response against the start-of-cycle table.
module noc_txn_tracker
    import noc_mon_pkg::*;
#(
    parameter int MAX_OUT = DEF_MAX_OUT,
    parameter int CH_W    = 2,
    parameter int ID_W    = DEF_ID_W,
    parameter int OCC_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [31:0]      now,
    input  logic             req_en,
    input  logic [CH_W-1:0]  req_ch,
    input  logic [ID_W-1:0]  req_id,
    input  logic             rsp_en,
    input  logic [CH_W-1:0]  rsp_ch,
    input  logic [ID_W-1:0]  rsp_id,
    output logic             req_drop,
    output logic             rsp_hit,
    output logic [31:0]      rsp_lat,
    output logic [OCC_W-1:0] occupancy,
    output logic [OCC_W-1:0] occ_nxt
);

    localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    txn_entry_t         tbl [MAX_OUT];
    logic [MAX_OUT-1:0] vld;
    logic [MAX_OUT-1:0] hit_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   match_idx;
    logic               full;
    logic               alloc;

    for (genvar i = 0; i < MAX_OUT; i++) begin : g_ent
        assign vld[i]     = tbl[i].valid;
        assign hit_vec[i] = tbl[i].valid
                         && (tbl[i].ch == TXN_CH_W'(rsp_ch))
                         && (tbl[i].id == TXN_ID_W'(rsp_id));
    end

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        free_idx  = '0;
        match_idx = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!vld[i])
                free_idx = IDX_W'(i);
            if (hit_vec[i])
                match_idx = IDX_W'(i);
        end
    end

    assign full     = &vld;
    assign alloc    = req_en && !full;
    assign req_drop = req_en && full;
    assign rsp_hit  = rsp_en && (|hit_vec);
    assign rsp_lat  = now - tbl[match_idx].ts;
    assign occ_nxt  = occupancy + OCC_W'(alloc) - OCC_W'(rsp_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUT; i++)
                tbl[i] <= '0;
            occupancy <= '0;
        end else if (clear) begin
            for (int i = 0; i < MAX_OUT; i++)
                tbl[i] <= '0;
            occupancy <= '0;
        end else begin
            // free_idx is never a valid entry, so it cannot collide with match_idx.
            if (rsp_hit)
                tbl[match_idx].valid <= 1'b0;
            if (alloc)
                tbl[free_idx] <= '{valid: 1'b1, ch: TXN_CH_W'(req_ch),
                                   id: TXN_ID_W'(req_id), ts: now};
            occupancy <= occ_nxt;
        end
    end

endmodule

// File: rtl/noc_perf_monitor.sv
// Multi-channel NoC performance monitor: windowed per-channel latency, count and
// byte statistics with a throttle recommendation for the next window.
module noc_perf_monitor
    import noc_mon_pkg::*;
#(
    parameter int   NUM_CH        = DEF_NUM_CH,
    parameter int   ID_W          = DEF_ID_W,
    parameter int   MAX_OUT       = DEF_MAX_OUT,
    parameter int   WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int   LAT_THRESH    = DEF_LAT_THRESH,
    localparam int  CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int  OCC_W         = $clog2(MAX_OUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mon_en,
    input  logic                    req_valid,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [ID_W-1:0]         req_id,
    input  logic [15:0]             req_bytes,
    input  logic                    rsp_valid,
    input  logic [CH_W-1:0]         rsp_ch,
    input  logic [ID_W-1:0]         rsp_id,
    output logic                    stat_valid,
    output logic [NUM_CH-1:0][31:0] stat_lat_sum,
    output logic [NUM_CH-1:0][31:0] stat_lat_max,
    output logic [NUM_CH-1:0][31:0] stat_cnt,
    output logic [NUM_CH-1:0][31:0] stat_bytes,
    output logic [NUM_CH-1:0]       throttle,
    output logic [OCC_W-1:0]        occupancy,
    output logic [OCC_W-1:0]        occ_hwm,
    output logic [31:0]             drop_cnt,
    output logic [31:0]             orphan_cnt
);

    localparam int              WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    mon_state_t       state;
    logic [31:0]      now;
    logic [WIN_W-1:0] win_cnt;
    logic             active;
    logic             win_close;
    logic             req_drop;
    logic             rsp_hit;
    logic [31:0]      rsp_lat;
    logic [OCC_W-1:0] occ_nxt;

    // A RUN cycle with mon_en low is treated as already idle: its events are discarded.
    assign active    = (state == RUN) && mon_en;
    assign win_close = (win_cnt == WIN_LAST);

    noc_txn_tracker #(
        .MAX_OUT (MAX_OUT),
        .CH_W    (CH_W),
        .ID_W    (ID_W),
        .OCC_W   (OCC_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (!active),
        .now       (now),
        .req_en    (active && req_valid),
        .req_ch    (req_ch),
        .req_id    (req_id),
        .rsp_en    (active && rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_id    (rsp_id),
        .req_drop  (req_drop),
        .rsp_hit   (rsp_hit),
        .rsp_lat   (rsp_lat),
        .occupancy (occupancy),
        .occ_nxt   (occ_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            now        <= '0;
            win_cnt    <= '0;
            stat_valid <= 1'b0;
            occ_hwm    <= '0;
            drop_cnt   <= '0;
            orphan_cnt <= '0;
        end else begin
            now        <= now + 32'd1;
            stat_valid <= active && win_close;
            case (state)
                IDLE: begin
                    win_cnt    <= '0;
                    occ_hwm    <= '0;
                    drop_cnt   <= '0;
                    orphan_cnt <= '0;
                    if (mon_en)
                        state <= RUN;
                end
                RUN: begin
                    if (!mon_en) begin
                        state      <= IDLE;
                        win_cnt    <= '0;
                        occ_hwm    <= '0;
                        drop_cnt   <= '0;
                        orphan_cnt <= '0;
                    end else begin
                        win_cnt    <= win_close ? '0 : win_cnt + 1'b1;
                        if (occ_nxt > occ_hwm)
                            occ_hwm <= occ_nxt;
                        drop_cnt   <= sat_add32(drop_cnt, {31'd0, req_drop});
                        orphan_cnt <= sat_add32(orphan_cnt, {31'd0, rsp_valid && !rsp_hit});
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0] sum_q, max_q, cnt_q, bytes_q;
        logic [31:0] sum_nxt, max_nxt, cnt_nxt, bytes_nxt;
        logic [31:0] s_sum, s_max, s_cnt, s_bytes;
        logic        thr_q, thr_nxt;
        logic        req_here, rsp_here;

        assign req_here = req_valid && (req_ch == CH_W'(c));
        assign rsp_here = rsp_hit && (rsp_ch == CH_W'(c));

        // The close cycle's own events are folded in before the snapshot.
        always_comb begin
            bytes_nxt = req_here ? sat_add32(bytes_q, {16'd0, req_bytes}) : bytes_q;
            sum_nxt   = rsp_here ? sat_add32(sum_q, rsp_lat) : sum_q;
            cnt_nxt   = rsp_here ? sat_add32(cnt_q, 32'd1) : cnt_q;
            max_nxt   = (rsp_here && (rsp_lat > max_q)) ? rsp_lat : max_q;
            thr_nxt   = (cnt_nxt != 32'd0)
                     && ({32'd0, sum_nxt} > 64'(LAT_THRESH) * {32'd0, cnt_nxt});
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                max_q   <= '0;
                cnt_q   <= '0;
                bytes_q <= '0;
                s_sum   <= '0;
                s_max   <= '0;
                s_cnt   <= '0;
                s_bytes <= '0;
                thr_q   <= 1'b0;
            end else if (!active) begin
                sum_q   <= '0;
                max_q   <= '0;
                cnt_q   <= '0;
                bytes_q <= '0;
            end else if (win_close) begin
                s_sum   <= sum_nxt;
                s_max   <= max_nxt;
                s_cnt   <= cnt_nxt;
                s_bytes <= bytes_nxt;
                thr_q   <= thr_nxt;
                sum_q   <= '0;
                max_q   <= '0;
                cnt_q   <= '0;
                bytes_q <= '0;
            end else begin
                sum_q   <= sum_nxt;
                max_q   <= max_nxt;
                cnt_q   <= cnt_nxt;
                bytes_q <= bytes_nxt;
            end
        end

        assign stat_lat_sum[c] = s_sum;
        assign stat_lat_max[c] = s_max;
        assign stat_cnt[c]     = s_cnt;
        assign stat_bytes[c]   = s_bytes;
        assign throttle[c]     = thr_q;
    end

endmodule
